// File: rtl/sp_pkg.sv
// Shared definitions for the sp_mc multicycle core: opcodes, ALU ops, FSM states,
// and the instruction field decoder.
package sp_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ANDI = 6'd1;
  localparam logic [5:0] OP_ORI  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_SUBI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_BNE  = 6'd8;

  localparam logic [5:0] FN_AND = 6'd0;
  localparam logic [5:0] FN_OR  = 6'd1;
  localparam logic [5:0] FN_ADD = 6'd2;
  localparam logic [5:0] FN_SUB = 6'd3;
  localparam logic [5:0] FN_SLT = 6'd4;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;

  typedef enum logic [2:0] {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL} alu_op_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
  } fields_t;

  // Layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0]; imm overlays [15:0].
  function automatic fields_t get_fields(input logic [31:0] i);
    fields_t f;
    f.op    = i[31:26];
    f.rs    = i[25:21];
    f.rt    = i[20:16];
    f.rd    = i[15:11];
    f.shamt = i[10:6];
    f.func  = i[5:0];
    f.imm   = i[15:0];
    return f;
  endfunction

endpackage

// File: rtl/sp_alu.sv
// Combinational ALU for sp_mc: and/or/add/sub/signed slt/sll plus an equality flag.
module sp_alu
  import sp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] y,
  output logic              eq
);

  logic lt;

  always_comb begin
    lt = $signed(a) < $signed(b);
    eq = (a == b);
    y  = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, lt};
      default: y = a << shamt;
    endcase
  end

endmodule

// File: rtl/sp_mc.sv
// sp_mc: single-issue multicycle core. One instruction is accepted in IDLE, executed,
// optionally does one data-memory access, then retires with a one-cycle out_valid pulse.
module sp_mc
  import sp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int MEM_AW  = 12,
  parameter int R0_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       inst,
  output logic              out_valid,
  output logic [31:0]       inst_addr,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  // Handshakes: inst is taken only when in_valid is high in IDLE (no back-pressure
  // signal; in_valid elsewhere is dropped). mem_req stays high with stable
  // we/addr/wdata until the cycle mem_ack is high; that edge completes the access.
  state_t            state, state_d;
  logic [31:0]       inst_q;
  logic              err_q;
  logic [DATA_W-1:0] r [0:NREG-1];
  fields_t           f;
  logic [IW-1:0]     rs_i, rt_i, rd_i, wr_i;
  logic [DATA_W-1:0] rs_v, rt_v, imm_s, imm_z, alu_b, alu_y;
  alu_op_t           alu_op;
  logic              alu_eq, wr_en, alu_wr_ok, lw_wr_ok, is_mem, illegal, taken;
  logic [31:0]       pc_next;

  assign f         = get_fields(inst_q);
  assign rs_i      = IW'(f.rs);
  assign rt_i      = IW'(f.rt);
  assign rd_i      = IW'(f.rd);
  assign rs_v      = r[rs_i];
  assign rt_v      = r[rt_i];
  assign imm_s     = DATA_W'($signed(f.imm));
  assign imm_z     = DATA_W'(f.imm);
  assign dbg_state = state;

  sp_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (alu_op),
    .a     (rs_v),
    .b     (alu_b),
    .shamt (f.shamt),
    .y     (alu_y),
    .eq    (alu_eq)
  );

  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = rt_v;
    wr_en   = 1'b0;
    wr_i    = rt_i;
    is_mem  = (f.op == OP_LW) || (f.op == OP_SW);
    illegal = (f.op > OP_BNE);
    case (f.op)
      OP_R: begin
        wr_en = 1'b1;
        wr_i  = rd_i;
        case (f.func)
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_SLL;
        endcase
      end
      OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_z; wr_en = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_z; wr_en = 1'b1; end
      OP_ADDI: begin alu_op = ALU_ADD; alu_b = imm_s; wr_en = 1'b1; end
      OP_SUBI: begin alu_op = ALU_SUB; alu_b = imm_s; wr_en = 1'b1; end
      OP_LW, OP_SW: alu_b = imm_s;
      default: ;
    endcase
    alu_wr_ok = wr_en && !((R0_ZERO != 0) && (wr_i == '0));
    lw_wr_ok  = !((R0_ZERO != 0) && (rt_i == '0));
    taken     = ((f.op == OP_BEQ) && alu_eq) || ((f.op == OP_BNE) && !alu_eq);
    // During MEM the latched op is lw/sw, so taken is 0 and this is simply +4.
    pc_next   = inst_addr + 32'd4 + (taken ? {{14{f.imm[15]}}, f.imm, 2'b00} : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    out_valid = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: if (in_valid) state_d = EXEC;
      EXEC: state_d = is_mem ? MEM : DONE;
      MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        err       = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q    <= '0;
      inst_addr <= '0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < NREG; i++) r[i] <= '0;
    end else begin
      if (state == IDLE && in_valid) inst_q <= inst;
      if (state == EXEC) begin
        err_q <= illegal;
        if (is_mem) begin
          mem_we    <= (f.op == OP_SW);
          mem_addr  <= MEM_AW'(alu_y);
          mem_wdata <= rt_v;
        end else begin
          inst_addr <= pc_next;
          if (alu_wr_ok) r[wr_i] <= alu_y;
        end
      end
      if (state == MEM && mem_ack) begin
        inst_addr <= pc_next;
        if (!mem_we && lw_wr_ok) r[rt_i] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sp_mc.sv
// Directed bench for sp_mc: a driver issues instructions and pushes the expected
// retirement into exp_q; a negedge monitor pops and compares on every out_valid.
module tb_sp_mc;

  localparam int DATA_W = 32;
  localparam int MEM_AW = 12;
  localparam int EXP_W  = 65;

  logic              clk, rst_n, in_valid, out_valid, err, mem_req, mem_we, mem_ack;
  logic [31:0]       inst, inst_addr;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;

  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [EXP_W-1:0]  mon_e;
  logic [31:0]       exp_r [0:31];

  sp_mc #(.DATA_W(DATA_W), .NREG(32), .MEM_AW(MEM_AW), .R0_ZERO(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inst      (inst),
    .out_valid (out_valid),
    .inst_addr (inst_addr),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    int bad;
    bad = 0;
    for (int i = 31; i >= 0; i--) if (dut.r[i] !== exp_r[i]) bad = i;
    check(name, {32'd0, dut.r[bad]}, {32'd0, exp_r[bad]});
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 expected=0 inst_addr=%0h", inst_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("retire_cycle", 64'(cyc), {32'd0, mon_e[64:33]});
        check("err", {63'd0, err}, {63'd0, mon_e[32]});
        check("inst_addr", {32'd0, inst_addr}, {32'd0, mon_e[31:0]});
      end
    end
  end

  // driver: called at a negedge with the DUT in IDLE; returns at a negedge in IDLE
  task automatic issue(input logic [31:0] i, input logic [31:0] exp_addr, input logic exp_err,
                       input int widx, input logic [31:0] wval, input int delay,
                       input logic exp_we, input logic [MEM_AW-1:0] exp_maddr, input logic [31:0] mdata);
    int c0;
    c0 = cyc;
    exp_q.push_back({32'(c0 + 2 + delay), exp_err, exp_addr});
    in_valid = 1'b1;
    inst     = i;
    @(negedge clk);
    inst = enc_i(3, 0, 20, 16'h0055);
    check("mem_req_exec", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    inst     = '0;
    for (int k = 1; k <= delay; k++) begin
      check("mem_req_hold", {63'd0, mem_req}, 64'd1);
      if (k == delay) begin
        check("mem_we", {63'd0, mem_we}, {63'd0, exp_we});
        check("mem_addr", 64'(mem_addr), 64'(exp_maddr));
        if (exp_we) check("mem_wdata", 64'(mem_wdata), 64'(mdata));
        mem_ack   = 1'b1;
        mem_rdata = mdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (delay > 0) check("mem_req_drop", {63'd0, mem_req}, 64'd0);
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) @(negedge clk);
    if (out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL retire_timeout actual=no_out_valid expected=out_valid");
    end
    @(negedge clk);
    if (widx >= 0) exp_r[widx] = wval;
    check_regs("regs");
  endtask

  task automatic alu(input logic [31:0] i, input logic [31:0] exp_addr, input int widx, input logic [31:0] wval);
    issue(i, exp_addr, 1'b0, widx, wval, 0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_r[i] = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inst      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_inst_addr", {32'd0, inst_addr}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check_regs("rst_regs");
    rst_n = 1'b1;
    @(negedge clk);

    alu(enc_i(3, 0, 1, 16'hFFFD), 32'h04, 1, 32'hFFFF_FFFD);   // addi r1,r0,-3
    alu(enc_r(1, 0, 2, 0, 4),     32'h08, 2, 32'h1);           // slt r2,r1,r0
    alu(enc_i(3, 0, 1, 16'd5),    32'h0C, 1, 32'h5);
    alu(enc_i(3, 0, 2, 16'd9),    32'h10, 2, 32'h9);
    issue(enc_i(6, 0, 1, 16'd7),  32'h14, 1'b0, -1, '0, 3, 1'b1, 12'h007, 32'h5);  // sw r1,7(r0)
    alu(enc_i(3, 0, 1, 16'd9),    32'h18, 1, 32'h9);
    alu(enc_i(2, 0, 3, 16'h00F0), 32'h1C, 3, 32'hF0);          // ori
    alu(enc_i(1, 3, 4, 16'h0030), 32'h20, 4, 32'h30);          // andi
    alu(enc_i(7, 1, 2, 16'hFFFE), 32'h1C, -1, '0);             // beq taken backwards
    alu(enc_i(8, 1, 2, 16'hFFFE), 32'h20, -1, '0);             // bne not taken
    alu(enc_i(8, 1, 3, 16'd3),    32'h30, -1, '0);             // bne taken forwards
    alu(enc_i(7, 1, 3, 16'hFFFE), 32'h34, -1, '0);             // beq not taken
    alu(enc_r(1, 2, 5, 0, 2),     32'h38, 5, 32'h12);          // add
    alu(enc_r(3, 1, 6, 0, 3),     32'h3C, 6, 32'hE7);          // sub
    alu(enc_r(3, 1, 7, 0, 1),     32'h40, 7, 32'hF9);          // or
    alu(enc_r(3, 4, 8, 0, 0),     32'h44, 8, 32'h30);          // and
    alu(enc_r(1, 0, 9, 4, 7),     32'h48, 9, 32'h90);          // unknown func -> sll
    alu(enc_i(4, 0, 10, 16'd1),   32'h4C, 10, 32'hFFFF_FFFF);  // subi wraps
    alu(enc_r(1, 3, 11, 0, 4),    32'h50, 11, 32'h1);
    alu(enc_r(3, 10, 12, 0, 4),   32'h54, 12, 32'h0);          // 0xF0 < -1 is false
    alu(enc_i(2, 0, 13, 16'h8000), 32'h58, 13, 32'h0000_8000); // zero-extended
    alu(enc_i(3, 0, 14, 16'h8000), 32'h5C, 14, 32'hFFFF_8000); // sign-extended
    issue({6'h3F, 26'h123_4567}, 32'h60, 1'b1, -1, '0, 0, 1'b0, '0, '0);
    alu(enc_i(3, 0, 0, 16'd1),    32'h64, -1, '0);             // r0 is hardwired
    issue(enc_i(5, 1, 15, 16'd2), 32'h68, 1'b0, 15, 32'hCAFE_BABE, 2, 1'b0, 12'h00B, 32'hCAFE_BABE);

    // lw aborted by reset while the request is outstanding
    in_valid = 1'b1;
    inst     = enc_i(5, 1, 16, 16'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_mem_req_before", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_mem_req", {63'd0, mem_req}, 64'd0);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_inst_addr", {32'd0, inst_addr}, 64'd0);
    for (int i = 0; i < 32; i++) exp_r[i] = '0;
    check_regs("abort_regs");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sp_mc.md
SP_MC -- requirements
Module: sp_mc

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width (>=16).
REQ-002 Parameter NREG, default 32, register count; index width = $clog2(NREG); instruction fields use their low index bits.
REQ-003 Parameter MEM_AW, default 12, data-memory word-address width.
REQ-004 Parameter R0_ZERO, default 0; 1 = r[0] reads 0 and ignores writes.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  inst valid this cycle.
REQ-008 inst  input  32  instruction word.
REQ-009 out_valid  output  1  one-cycle pulse: instruction retired.
REQ-010 inst_addr  output  32  byte address of next instruction.
REQ-011 err  output  1  valid with out_valid; 1 = illegal opcode.
REQ-012 mem_req  output  1  data-memory request, held until mem_ack.
REQ-013 mem_we  output  1  1 = store, 0 = load; stable while mem_req.
REQ-014 mem_addr  output  MEM_AW  word address; stable while mem_req.
REQ-015 mem_wdata  output  DATA_W  store data; stable while mem_req.
REQ-016 mem_rdata  input  DATA_W  load data, valid when mem_ack.
REQ-017 mem_ack  input  1  completes request in the same cycle.

Function
REQ-018 FSM states IDLE, EXEC, MEM, DONE; IDLE->EXEC on in_valid (inst latched); EXEC->MEM for lw/sw, else EXEC->DONE; MEM->DONE on mem_ack; DONE->IDLE unconditionally.
REQ-019 out_valid=1 only in DONE; ALU/branch/illegal latency = 2 cycles from the in_valid edge; lw/sw = 2 + cycles until mem_ack.
REQ-020 in_valid outside IDLE is ignored; no queuing.
REQ-021 Opcode 0 R-type by func: 0 and, 1 or, 2 add, 3 sub, 4 slt (signed, result 1/0), any other func sll: rd = rs << shamt.
REQ-022 Opcodes 1 andi, 2 ori use zero-extended imm; 3 addi, 4 subi, 5 lw, 6 sw, 7 beq, 8 bne use sign-extended imm to DATA_W.
REQ-023 lw/sw address = (r[rs] + sext(imm)) truncated to MEM_AW bits; lw writes mem_rdata to rt at the mem_ack edge.
REQ-024 All arithmetic modulo 2^DATA_W; no overflow flag.
REQ-025 inst_addr updates at the DONE entry edge: taken beq (r[rs]==r[rt]) / bne (!=) -> inst_addr + 4 + (sext(imm) << 2), else + 4; 32-bit wrap.
REQ-026 Opcode >8: err=1, no register or memory change, inst_addr + 4.
REQ-027 Register write happens at the EXEC->DONE edge (ALU) or the mem_ack edge (lw), never both; write to r[0] obeys R0_ZERO.
REQ-028 mem_req rises on EXEC->MEM and falls on the edge after mem_ack; mem_ack outside MEM is ignored.

Reset
REQ-029 rst_n=0 at a clock edge: state IDLE, out_valid=0, err=0, mem_req=0, mem_we=0, inst_addr=0, all r[]=0; outputs at 0 in the cycle after.
REQ-030 Reset during MEM aborts the request: mem_req drops, no write-back, no out_valid.

Structure
REQ-031 Package sp_pkg holds opcode/func constants, the FSM state enum, and a field-extraction function.
REQ-032 One sub-module sp_alu (combinational, DATA_W-parametrised): ops and/or/add/sub/slt/sll plus eq flag.
REQ-033 Register file is an internal array named r[0:NREG-1], visible hierarchically to the bench.

Verification
REQ-034 Reset, then read -> inst_addr=0, out_valid=0, all r=0, mem_req=0.
REQ-035 addi r1,r0,-3 then slt r2,r1,r0 -> r1=0xFFFFFFFD, r2=1, out_valid 2 cycles after each in_valid, inst_addr 4 then 8.
REQ-036 r1=5 at addr 0x10; sw r1,7(r0) with mem_ack after 3 cycles -> mem_addr=7, mem_wdata=5, mem_req high 3 cycles, out_valid 5 cycles after in_valid, inst_addr=0x14.
REQ-037 r1=r2=9 at addr 0x20; beq r1,r2,-2 -> inst_addr=0x1C; bne same operands -> 0x24.
REQ-038 Opcode 0x3F -> err=1 with out_valid, regs unchanged, inst_addr+4; R0_ZERO=1 and addi r0,r0,1 -> r[0] stays 0.
REQ-039 lw with rst_n=0 asserted while mem_req=1 -> mem_req=0 next cycle, no out_valid, all r=0, inst_addr=0.
